sysid_reader: RTL and testbench
===============================

Name: sysid_reader

Overview:
- Avalon-MM master that reads a Qsys system-ID slave and checks it against build-time constants.
- The slave is word address 0 for the ID and word address 1 for the timestamp.
- Sits beside the Nios II or boot logic. It gives a hardware "correct bitstream/software pairing" flag: a status LED and a gate for game start-up.
- Performs two single reads per start request. Handles waitrequest and, optionally, readdatavalid. Times out if the slave never responds.

Parameters:
- EXPECTED_ID, 0: value the ID word (address 0) must equal.
- EXPECTED_TIMESTAMP, 1476685446: value the timestamp word (address 1) must equal.
- CHECK_TIMESTAMP, 1: 1 means ts_ok participates in pass; 0 means the timestamp is still read and captured, but pass ignores ts_ok.
- USE_READDATAVALID, 0: 0 means data is sampled in the cycle the command is accepted (readLatency 0, matching sysid); 1 means data is sampled when avm_readdatavalid=1.
- TIMEOUT_CYCLES, 255: maximum cycles allowed per read phase (command plus data wait); range 1..65535.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a check sequence; sampled only in IDLE or DONE.
- avm_address  out  1  word address (0 = ID, 1 = timestamp).
- avm_read  out  1  read command.
- avm_readdata  in  32  read data.
- avm_waitrequest  in  1  slave stall; tie to 0 for sysid.
- avm_readdatavalid  in  1  data valid; used only when USE_READDATAVALID=1.
- busy  out  1  high from start acceptance until DONE is entered.
- done  out  1  high while in DONE.
- pass  out  1  id_ok & (ts_ok | ~CHECK_TIMESTAMP) & ~timeout; valid while done=1.
- id_ok  out  1  captured ID == EXPECTED_ID.
- ts_ok  out  1  captured timestamp == EXPECTED_TIMESTAMP.
- timeout  out  1  a read phase exceeded TIMEOUT_CYCLES.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.

Behaviour:
- Reset:
  - state=IDLE; all 1-bit outputs 0; avm_address=0; id_value=ts_value=0; timeout counter=0.
  - Reset mid-read drops avm_read in the next cycle, with no completion of the transaction.
- States: IDLE, ID_CMD, ID_WAIT, TS_CMD, TS_WAIT, DONE. All outputs are registered.
- IDLE:
  - start=1 → ID_CMD.
  - Clear id_ok, ts_ok, timeout, pass, id_value and ts_value.
  - Set busy=1, avm_read=1, avm_address=0.
- ID_CMD: avm_read is held, with the address stable, until a cycle with avm_read=1 and avm_waitrequest=0 (accept). Then:
  - USE_READDATAVALID=0: capture avm_readdata into id_value on the accept edge → TS_CMD.
  - USE_READDATAVALID=1: drop avm_read → ID_WAIT.
- ID_WAIT:
  - On avm_readdatavalid=1, capture id_value → TS_CMD.
  - readdatavalid arriving in the same cycle as the accept is treated as data for that read; go straight to TS_CMD.
- TS_CMD / TS_WAIT:
  - Same as ID_CMD / ID_WAIT with avm_address=1.
  - Capture into ts_value, then → DONE.
- DONE:
  - done=1 and busy=0.
  - id_ok, ts_ok and pass are registered from the captured values on entry.
  - Outputs hold until start=1. start=1 in DONE behaves exactly as start in IDLE (restart), and done falls in the next cycle.
- Start while busy is ignored. readdatavalid outside the *_WAIT states is ignored.
- Timeout:
  - The per-phase counter resets to 0 on entry to ID_CMD and to TS_CMD, and increments each cycle spent in CMD or WAIT.
  - When the counter reaches TIMEOUT_CYCLES without completion: timeout=1, avm_read=0, → DONE with id_ok/ts_ok/pass=0.
  - Completion in the same cycle the limit is reached counts as success.
- Latency (waitrequest=0, USE_READDATAVALID=0): start sampled at edge N; ID read in cycle N+1; TS read in cycle N+2; done=1 from N+3.
- Comparisons are full 32-bit unsigned equality. No other arithmetic is performed.

Test Plan:
- Combinational sysid model (addr ? 1476685446 : 0), waitrequest=0, defaults → done high 3 cycles after start, with id_value=0, ts_value=1476685446, id_ok=ts_ok=pass=1, and avm_read high exactly 2 cycles (addresses 0 then 1).
- Slave returns timestamp 1476685447 → ts_ok=0, pass=0. Repeat with CHECK_TIMESTAMP=0 → pass=1.
- waitrequest held 4 cycles on each read → address/read stable while stalled; done at start+11; values correct.
- USE_READDATAVALID=1, data 2 cycles after accept → correct capture. A readdatavalid pulse injected in DONE → no change to outputs.
- waitrequest stuck at 1 with TIMEOUT_CYCLES=10 → avm_read drops, and timeout=1, pass=0, done=1 at start+11. A subsequent start with a healthy slave → pass=1 and timeout cleared.
- reset asserted during TS_CMD → avm_read=0 and all outputs at reset values the next cycle. start during busy → ignored, with no extra reads.

Source files
------------

// File: rtl/sysid_reader.sv
// -----------------------------------------------------------------------------
// sysid_reader
//
// Avalon-MM read master that fetches the two words of a Qsys system-ID slave
// (word 0 = ID, word 1 = build timestamp) and compares them against build-time
// constants. The result drives a "bitstream and software belong together" flag
// for a status LED and for gating game start-up.
//
// Ports:
//   clock              system clock, everything on the rising edge
//   reset              synchronous, active-high
//   start              begin a check; only honoured in IDLE or DONE
//   avm_address        word address (0 = ID, 1 = timestamp)
//   avm_read           read command
//   avm_readdata       read data from the slave
//   avm_waitrequest    slave stall
//   avm_readdatavalid  read data valid (only used when USE_READDATAVALID = 1)
//   busy               high from start acceptance until DONE is entered
//   done               high while in DONE
//   pass               id_ok & (ts_ok | ~CHECK_TIMESTAMP) & ~timeout
//   id_ok / ts_ok      captured word equals its expected constant
//   timeout            a read phase ran out of cycles
//   id_value/ts_value  captured ID and timestamp words
//
// Handshake: a read command is accepted in a cycle where avm_read = 1 and
// avm_waitrequest = 0; address and read are held stable until then. With
// USE_READDATAVALID = 0 the data is taken in the accept cycle; otherwise it is
// taken in the first cycle with avm_readdatavalid = 1, which may coincide with
// the accept cycle.
// -----------------------------------------------------------------------------
module sysid_reader #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1476685446,
    parameter bit          CHECK_TIMESTAMP    = 1'b1,
    parameter bit          USE_READDATAVALID  = 1'b0,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ID_CMD  = 3'd1,
        S_ID_WAIT = 3'd2,
        S_TS_CMD  = 3'd3,
        S_TS_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // The phase has used up its budget when the counter sits at LIMIT-1 and
    // this cycle brings no completion.
    localparam logic [15:0] LIMIT_M1 = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_addr;
    logic        r_read;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic w_in_cmd;
    logic w_in_wait;
    logic w_in_id;
    logic w_accept;
    logic w_data;
    logic w_limit;
    logic w_id_match;
    logic w_ts_match;

    assign w_in_cmd   = (r_state == S_ID_CMD)  || (r_state == S_TS_CMD);
    assign w_in_wait  = (r_state == S_ID_WAIT) || (r_state == S_TS_WAIT);
    assign w_in_id    = (r_state == S_ID_CMD)  || (r_state == S_ID_WAIT);
    assign w_accept   = w_in_cmd && r_read && !avm_waitrequest;
    // Data for the current phase: either in the accept cycle (readLatency 0)
    // or on readdatavalid while the command is being accepted or afterwards.
    assign w_data     = USE_READDATAVALID ? ((w_accept || w_in_wait) && avm_readdatavalid)
                                          : w_accept;
    assign w_limit    = (r_cnt == LIMIT_M1);
    assign w_id_match = (r_id_value == EXPECTED_ID);
    // The timestamp is compared as it is captured, so DONE's flags are ready
    // in the same edge that enters DONE.
    assign w_ts_match = (avm_readdata == EXPECTED_TIMESTAMP);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= 1'b0;
            r_read     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_ID_CMD;
                        r_cnt      <= '0;
                        r_addr     <= 1'b0;
                        r_read     <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_id_ok    <= 1'b0;
                        r_ts_ok    <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_id_value <= '0;
                        r_ts_value <= '0;
                    end
                end
                S_ID_CMD, S_ID_WAIT, S_TS_CMD, S_TS_WAIT: begin
                    // Completion wins over the limit in the same cycle.
                    if (w_data) begin
                        if (w_in_id) begin
                            r_id_value <= avm_readdata;
                            r_state    <= S_TS_CMD;
                            r_cnt      <= '0;
                            r_addr     <= 1'b1;
                            r_read     <= 1'b1;
                        end else begin
                            r_ts_value <= avm_readdata;
                            r_state    <= S_DONE;
                            r_read     <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_id_ok    <= w_id_match;
                            r_ts_ok    <= w_ts_match;
                            r_pass     <= w_id_match && (w_ts_match || !CHECK_TIMESTAMP);
                        end
                    end else if (w_limit) begin
                        r_state   <= S_DONE;
                        r_read    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_id_ok   <= 1'b0;
                        r_ts_ok   <= 1'b0;
                        r_pass    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                        // Only reachable with readdatavalid: command taken,
                        // data still outstanding.
                        if (w_accept) begin
                            r_read  <= 1'b0;
                            r_state <= w_in_id ? S_ID_WAIT : S_TS_WAIT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign avm_address = r_addr;
    assign avm_read    = r_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout     = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_reader.sv
// -----------------------------------------------------------------------------
// tb_sysid_reader
//
// Three reader instances share one clock and reset:
//   u_a : defaults (readLatency 0, timestamp checked, 255-cycle budget)
//   u_b : timestamp ignored by pass, 10-cycle budget
//   u_c : readdatavalid mode
// Each has its own behavioural system-ID slave with programmable stall length
// per word, a stuck-waitrequest mode and (for u_c) a readdatavalid delay.
// Offsets are counted in cycles after the edge that samples start.
// -----------------------------------------------------------------------------
module tb_sysid_reader;

    localparam logic [31:0] TS_OK  = 32'd1476685446;
    localparam logic [31:0] TS_BAD = 32'd1476685447;

    typedef struct {
        int          inst;
        logic [31:0] idw;
        logic [31:0] tsw;
        int          sid;
        int          sts;
        bit          stuck;
        int          dly;
        bit          xs;
    } stim_t;

    typedef struct {
        int          done_k;
        logic [31:0] idv;
        logic [31:0] tsv;
        bit          id_ok;
        bit          ts_ok;
        bit          pass;
        bit          to;
        int          rdcyc;
        int          acc;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic clock;
    logic reset;

    logic [2:0]       start_v;
    logic [2:0]       wr_v;
    logic [2:0]       rdv_v;
    logic [2:0]       stuck_v;
    logic [2:0][31:0] rdata_v;

    wire [2:0]        addr_v;
    wire [2:0]        read_v;
    wire [2:0]        busy_v;
    wire [2:0]        done_v;
    wire [2:0]        pass_v;
    wire [2:0]        idok_v;
    wire [2:0]        tsok_v;
    wire [2:0]        to_v;
    wire [2:0][31:0]  idv_v;
    wire [2:0][31:0]  tsv_v;

    logic [31:0] id_word [3];
    logic [31:0] ts_word [3];
    int          stall_id [3];
    int          stall_ts [3];
    int          stall_cnt [3];

    int          rdv_delay;
    logic        pend_valid;
    int          pend_left;
    logic [31:0] pend_data;
    logic        inj_rdv;
    logic [31:0] inj_data;

    int checks   = 0;
    int failures = 0;

    vec_t tbl [13];

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUTs ----------------
    sysid_reader u_a (
        .clock(clock), .reset(reset), .start(start_v[0]),
        .avm_address(addr_v[0]), .avm_read(read_v[0]), .avm_readdata(rdata_v[0]),
        .avm_waitrequest(wr_v[0]), .avm_readdatavalid(rdv_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .id_ok(idok_v[0]),
        .ts_ok(tsok_v[0]), .timeout(to_v[0]), .id_value(idv_v[0]), .ts_value(tsv_v[0])
    );

    sysid_reader #(.CHECK_TIMESTAMP(1'b0), .TIMEOUT_CYCLES(10)) u_b (
        .clock(clock), .reset(reset), .start(start_v[1]),
        .avm_address(addr_v[1]), .avm_read(read_v[1]), .avm_readdata(rdata_v[1]),
        .avm_waitrequest(wr_v[1]), .avm_readdatavalid(rdv_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .id_ok(idok_v[1]),
        .ts_ok(tsok_v[1]), .timeout(to_v[1]), .id_value(idv_v[1]), .ts_value(tsv_v[1])
    );

    sysid_reader #(.USE_READDATAVALID(1'b1)) u_c (
        .clock(clock), .reset(reset), .start(start_v[2]),
        .avm_address(addr_v[2]), .avm_read(read_v[2]), .avm_readdata(rdata_v[2]),
        .avm_waitrequest(wr_v[2]), .avm_readdatavalid(rdv_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .id_ok(idok_v[2]),
        .ts_ok(tsok_v[2]), .timeout(to_v[2]), .id_value(idv_v[2]), .ts_value(tsv_v[2])
    );

    // ---------------- slave models ----------------
    always_comb begin
        wr_v    = '0;
        rdv_v   = '0;
        rdata_v = '0;
        for (int i = 0; i < 3; i++) begin
            wr_v[i]    = read_v[i] & (stuck_v[i] |
                         (stall_cnt[i] < (addr_v[i] ? stall_ts[i] : stall_id[i])));
            rdata_v[i] = addr_v[i] ? ts_word[i] : id_word[i];
        end
        // u_c: data bus carries junk unless a valid word is being presented
        if (inj_rdv) begin
            rdv_v[2]   = 1'b1;
            rdata_v[2] = inj_data;
        end else if (rdv_delay == 0 && read_v[2] && !wr_v[2]) begin
            rdv_v[2]   = 1'b1;
        end else if (pend_valid && pend_left == 0) begin
            rdv_v[2]   = 1'b1;
            rdata_v[2] = pend_data;
        end else begin
            rdata_v[2] = 32'hBADBAD00;
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (read_v[i] && wr_v[i]) stall_cnt[i] <= stall_cnt[i] + 1;
            else                      stall_cnt[i] <= 0;
        end
        if (reset) begin
            pend_valid <= 1'b0;
            pend_left  <= 0;
        end else if (read_v[2] && !wr_v[2] && rdv_delay > 0) begin
            pend_valid <= 1'b1;
            pend_left  <= rdv_delay - 1;
            pend_data  <= addr_v[2] ? ts_word[2] : id_word[2];
        end else if (pend_valid) begin
            if (pend_left == 0) pend_valid <= 1'b0;
            else                pend_left  <= pend_left - 1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
        end
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk({tag, ".flags"}, {addr_v[i], read_v[i], busy_v[i], done_v[i],
                              pass_v[i], idok_v[i], tsok_v[i], to_v[i]}, 32'd0);
        chk({tag, ".id_value"}, idv_v[i], 32'd0);
        chk({tag, ".ts_value"}, tsv_v[i], 32'd0);
    endtask

    // While stalled, the command must be held with the same address on the
    // following cycle unless reset or a timeout intervened.
    logic [2:0] prev_stall = '0;
    logic [2:0] prev_addr  = '0;
    logic       prev_rst   = 1'b1;
    bit         mon_en     = 1'b0;

    always @(negedge clock) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                if (prev_stall[i] && !prev_rst && !reset && !to_v[i]) begin
                    chk($sformatf("u%0d.stall_hold", i), {read_v[i], addr_v[i]},
                        {1'b1, prev_addr[i]});
                end
            end
        end
        prev_stall <= read_v & wr_v;
        prev_addr  <= addr_v;
        prev_rst   <= reset;
    end

    // ---------------- reference model ----------------
    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        int   lim;
        int   dl;
        int   l_id;
        int   l_ts;
        e   = '{done_k: 0, idv: 32'd0, tsv: 32'd0, id_ok: 1'b0, ts_ok: 1'b0,
                pass: 1'b0, to: 1'b0, rdcyc: 0, acc: 0};
        lim = (s.inst == 1) ? 10 : 255;
        dl  = (s.inst == 2) ? s.dly : 0;
        if (s.stuck) begin
            e.to = 1'b1; e.done_k = lim + 1; e.rdcyc = lim;
            return e;
        end
        // A phase lasts stall + accept + data delay; it fails only if longer than the budget.
        l_id = s.sid + 1 + dl;
        l_ts = s.sts + 1 + dl;
        if (l_id > lim) begin
            e.to = 1'b1; e.done_k = lim + 1;
            e.rdcyc = imin(s.sid + 1, lim);
            e.acc = (s.sid + 1 <= lim) ? 1 : 0;
            return e;
        end
        e.idv = s.idw;
        if (l_ts > lim) begin
            e.to = 1'b1; e.done_k = l_id + lim + 1;
            e.rdcyc = s.sid + 1 + imin(s.sts + 1, lim);
            e.acc = 1 + ((s.sts + 1 <= lim) ? 1 : 0);
            return e;
        end
        e.done_k = l_id + l_ts + 1;
        e.tsv    = s.tsw;
        e.id_ok  = (s.idw == 32'd0);
        e.ts_ok  = (s.tsw == TS_OK);
        e.pass   = e.id_ok && (e.ts_ok || s.inst == 1);
        e.rdcyc  = s.sid + s.sts + 2;
        e.acc    = 2;
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic run_case(input stim_t s, input exp_t e, input string tag);
        int i;
        int k;
        int rd;
        int acc;
        i = s.inst;
        id_word[i]  = s.idw;
        ts_word[i]  = s.tsw;
        stall_id[i] = s.sid;
        stall_ts[i] = s.sts;
        stuck_v[i]  = s.stuck;
        if (i == 2) rdv_delay = s.dly;
        start_v[i] = 1'b1;
        @(negedge clock);
        start_v[i] = s.xs;
        k = 1; rd = 0; acc = 0;
        chk({tag, ".start_busy_done"}, {busy_v[i], done_v[i]}, 32'b10);
        while (k < 400 && !done_v[i]) begin
            rd  += int'(read_v[i]);
            acc += int'(read_v[i] & ~wr_v[i]);
            @(negedge clock);
            start_v[i] = 1'b0;
            k++;
        end
        stuck_v[i] = 1'b0;
        chk({tag, ".done_seen"}, done_v[i], 32'd1);
        if (done_v[i]) begin
            chk({tag, ".done_cycle"}, k, e.done_k);
            chk({tag, ".id_value"}, idv_v[i], e.idv);
            chk({tag, ".ts_value"}, tsv_v[i], e.tsv);
            chk({tag, ".idok_tsok_pass_to"}, {idok_v[i], tsok_v[i], pass_v[i], to_v[i]},
                {e.id_ok, e.ts_ok, e.pass, e.to});
            chk({tag, ".read_cycles"}, rd, e.rdcyc);
            chk({tag, ".accepts"}, acc, e.acc);
            chk({tag, ".busy_read"}, {busy_v[i], read_v[i]}, 32'd0);
            @(negedge clock);
            chk({tag, ".hold"}, {done_v[i], pass_v[i], to_v[i]}, {1'b1, e.pass, e.to});
        end
    endtask

    // ---------------- main ----------------
    initial begin
        stim_t s;
        exp_t  e;

        //           inst id        ts      sid sts stuck  dly xs
        tbl[0]  = '{s:'{0, 32'd0,   TS_OK,  0,  0,  1'b0, 0, 1'b0}, e:'{3,  32'd0, TS_OK,  1'b1, 1'b1, 1'b1, 1'b0, 2,  2}};
        tbl[1]  = '{s:'{0, 32'd0,   TS_BAD, 0,  0,  1'b0, 0, 1'b0}, e:'{3,  32'd0, TS_BAD, 1'b1, 1'b0, 1'b0, 1'b0, 2,  2}};
        tbl[2]  = '{s:'{1, 32'd0,   TS_BAD, 0,  0,  1'b0, 0, 1'b0}, e:'{3,  32'd0, TS_BAD, 1'b1, 1'b0, 1'b1, 1'b0, 2,  2}};
        tbl[3]  = '{s:'{0, 32'd0,   TS_OK,  4,  4,  1'b0, 0, 1'b0}, e:'{11, 32'd0, TS_OK,  1'b1, 1'b1, 1'b1, 1'b0, 10, 2}};
        tbl[4]  = '{s:'{2, 32'd0,   TS_OK,  0,  0,  1'b0, 2, 1'b0}, e:'{7,  32'd0, TS_OK,  1'b1, 1'b1, 1'b1, 1'b0, 2,  2}};
        tbl[5]  = '{s:'{2, 32'd0,   TS_OK,  0,  0,  1'b0, 0, 1'b0}, e:'{3,  32'd0, TS_OK,  1'b1, 1'b1, 1'b1, 1'b0, 2,  2}};
        tbl[6]  = '{s:'{1, 32'd0,   TS_OK,  0,  0,  1'b1, 0, 1'b0}, e:'{11, 32'd0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b1, 10, 0}};
        tbl[7]  = '{s:'{1, 32'd0,   TS_OK,  0,  0,  1'b0, 0, 1'b0}, e:'{3,  32'd0, TS_OK,  1'b1, 1'b1, 1'b1, 1'b0, 2,  2}};
        tbl[8]  = '{s:'{0, 32'd5,   TS_OK,  0,  0,  1'b0, 0, 1'b0}, e:'{3,  32'd5, TS_OK,  1'b0, 1'b1, 1'b0, 1'b0, 2,  2}};
        tbl[9]  = '{s:'{1, 32'd7,   TS_OK,  9,  10, 1'b0, 0, 1'b0}, e:'{21, 32'd7, 32'd0,  1'b0, 1'b0, 1'b0, 1'b1, 20, 1}};
        tbl[10] = '{s:'{1, 32'd0,   TS_OK,  9,  9,  1'b0, 0, 1'b0}, e:'{21, 32'd0, TS_OK,  1'b1, 1'b1, 1'b1, 1'b0, 20, 2}};
        tbl[11] = '{s:'{0, 32'd0,   TS_OK,  0,  0,  1'b0, 0, 1'b1}, e:'{3,  32'd0, TS_OK,  1'b1, 1'b1, 1'b1, 1'b0, 2,  2}};
        tbl[12] = '{s:'{2, 32'd0,   TS_OK,  2,  1,  1'b0, 3, 1'b0}, e:'{12, 32'd0, TS_OK,  1'b1, 1'b1, 1'b1, 1'b0, 5,  2}};

        for (int i = 0; i < 3; i++) begin
            id_word[i] = 32'd0; ts_word[i] = TS_OK;
            stall_id[i] = 0; stall_ts[i] = 0; stall_cnt[i] = 0;
        end
        stuck_v = '0; start_v = '0; rdv_delay = 0;
        inj_rdv = 1'b0; inj_data = 32'd0;

        // reset
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) chk_idle(i, $sformatf("reset_u%0d", i));
        mon_en = 1'b1;

        // directed table
        for (int n = 0; n < 13; n++) run_case(tbl[n].s, tbl[n].e, $sformatf("vec%0d", n));

        // stray readdatavalid while u_c sits in DONE
        @(negedge clock);
        inj_data = 32'hDEADBEEF;
        inj_rdv  = 1'b1;
        @(negedge clock);
        inj_rdv  = 1'b0;
        @(negedge clock);
        chk("rdv_in_done.flags", {done_v[2], busy_v[2], pass_v[2], to_v[2]}, 32'b1010);
        chk("rdv_in_done.id_value", idv_v[2], 32'd0);
        chk("rdv_in_done.ts_value", tsv_v[2], TS_OK);

        // reset during the timestamp read of u_a
        id_word[0] = 32'h0000_1234; ts_word[0] = TS_OK;
        stall_id[0] = 0; stall_ts[0] = 0;
        start_v[0] = 1'b1;
        @(negedge clock);
        start_v[0] = 1'b0;
        @(negedge clock);
        chk("rst_mid.ts_cmd", {read_v[0], addr_v[0], busy_v[0]}, 32'b111);
        chk("rst_mid.id_value", idv_v[0], 32'h0000_1234);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_idle(0, "rst_mid.after");
        repeat (3) @(negedge clock);
        chk_idle(0, "rst_mid.later");

        // randomized sequences against the model
        for (int n = 0; n < 40; n++) begin
            s.inst  = $urandom_range(0, 2);
            s.idw   = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
            s.tsw   = ($urandom_range(0, 3) == 0) ? (TS_OK ^ (32'd1 << $urandom_range(0, 31))) : TS_OK;
            s.sid   = (s.inst == 1) ? $urandom_range(0, 11) : $urandom_range(0, 5);
            s.sts   = (s.inst == 1) ? $urandom_range(0, 11) : $urandom_range(0, 5);
            s.stuck = (s.inst == 1) && ($urandom_range(0, 7) == 0);
            s.dly   = (s.inst == 2) ? $urandom_range(0, 3) : 0;
            s.xs    = ($urandom_range(0, 3) == 0);
            e = model(s);
            run_case(s, e, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
